// File: rtl/uart_transceiver_if.sv
// Byte-level handshake and serial pins of the 8N1 UART core.
// The master is the memory-mapped I/O side; the slave is the transceiver.
interface uart_transceiver_if;
  logic       i_RxSerial;
  logic [7:0] o_RxByte;
  logic       o_Rx_DV;
  logic [7:0] i_TxByte;
  logic       i_Tx_DV;
  logic       o_TxSerial;
  logic       o_TxActive;
  logic       o_TxDone;

  modport master (
    output i_RxSerial, i_TxByte, i_Tx_DV,
    input  o_RxByte, o_Rx_DV, o_TxSerial, o_TxActive, o_TxDone
  );

  modport slave (
    input  i_RxSerial, i_TxByte, i_Tx_DV,
    output o_RxByte, o_Rx_DV, o_TxSerial, o_TxActive, o_TxDone
  );
endinterface

// File: rtl/uart_transceiver.sv
// 8N1 UART with independent receiver and transmitter.
// The bit period is a fixed count of system clocks, with no oversampling.
module uart_transceiver #(
  parameter int unsigned CLKS_PER_BIT = 7292
) (
  input  logic               clk,
  input  logic               rst,
  uart_transceiver_if.slave  uart
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } state_e;

  // ---------------------------------------------------------------- receiver
  logic             rx_meta_q, rx_sync_q;
  state_e           rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_dv_q, rx_dv_d;
  logic             rx_bit_end_c, rx_half_c;

  assign rx_bit_end_c = (rx_cnt_q == BIT_LAST);
  assign rx_half_c    = (rx_cnt_q == HALF_LAST);

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart.i_RxSerial;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state_q <= S_IDLE;
    else     rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      S_IDLE:    if (!rx_sync_q) rx_state_d = S_START;
      S_START:   if (rx_half_c) rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
      S_DATA:    if (rx_bit_end_c && (rx_idx_q == 3'd7)) rx_state_d = S_STOP;
      S_STOP:    if (rx_bit_end_c) rx_state_d = S_CLEANUP;
      S_CLEANUP: rx_state_d = S_IDLE;
      default:   rx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_dv_d    = 1'b0;
    unique case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        rx_idx_d = 3'd0;
      end
      S_START: rx_cnt_d = rx_half_c ? '0 : rx_cnt_q + CNT_W'(1);
      S_DATA: begin
        if (rx_bit_end_c) begin
          rx_cnt_d             = '0;
          rx_shift_d[rx_idx_q] = rx_sync_q;
          rx_idx_d             = rx_idx_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      // A low stop bit is a framing error: the byte is dropped silently.
      S_STOP: begin
        if (rx_bit_end_c) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_byte_d = rx_shift_q;
            rx_dv_d   = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      S_CLEANUP: rx_cnt_d = '0;
      default:   rx_cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt_q   <= '0;
      rx_idx_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_byte_q  <= 8'h00;
      rx_dv_q    <= 1'b0;
    end else begin
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_dv_q    <= rx_dv_d;
    end
  end

  assign uart.o_RxByte = rx_byte_q;
  assign uart.o_Rx_DV  = rx_dv_q;

  // ------------------------------------------------------------- transmitter
  state_e           tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [2:0]       tx_idx_nxt_c;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_serial_q, tx_serial_d;
  logic             tx_active_q, tx_active_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_bit_end_c;

  assign tx_bit_end_c = (tx_cnt_q == BIT_LAST);
  assign tx_idx_nxt_c = tx_idx_q + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state_q <= S_IDLE;
    else     tx_state_q <= tx_state_d;
  end

  // The start request is only looked at in IDLE, so CLEANUP gives the user
  // a cycle to drop a level-held valid after seeing done.
  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      S_IDLE:    if (uart.i_Tx_DV) tx_state_d = S_START;
      S_START:   if (tx_bit_end_c) tx_state_d = S_DATA;
      S_DATA:    if (tx_bit_end_c && (tx_idx_q == 3'd7)) tx_state_d = S_STOP;
      S_STOP:    if (tx_bit_end_c) tx_state_d = S_CLEANUP;
      S_CLEANUP: tx_state_d = S_IDLE;
      default:   tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_cnt_d    = tx_cnt_q;
    tx_idx_d    = tx_idx_q;
    tx_data_d   = tx_data_q;
    tx_serial_d = tx_serial_q;
    tx_active_d = tx_active_q;
    tx_done_d   = 1'b0;
    unique case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d    = '0;
        tx_idx_d    = 3'd0;
        tx_serial_d = 1'b1;
        tx_active_d = 1'b0;
        if (uart.i_Tx_DV) begin
          tx_data_d   = uart.i_TxByte;
          tx_serial_d = 1'b0;
          tx_active_d = 1'b1;
        end
      end
      S_START: begin
        if (tx_bit_end_c) begin
          tx_cnt_d    = '0;
          tx_serial_d = tx_data_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (tx_bit_end_c) begin
          tx_cnt_d    = '0;
          tx_idx_d    = tx_idx_nxt_c;
          tx_serial_d = (tx_idx_q == 3'd7) ? 1'b1 : tx_data_q[tx_idx_nxt_c];
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (tx_bit_end_c) begin
          tx_cnt_d    = '0;
          tx_active_d = 1'b0;
          tx_done_d   = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      S_CLEANUP: tx_cnt_d = '0;
      default:   tx_cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt_q    <= '0;
      tx_idx_q    <= 3'd0;
      tx_data_q   <= 8'h00;
      tx_serial_q <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_data_q   <= tx_data_d;
      tx_serial_q <= tx_serial_d;
      tx_active_q <= tx_active_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign uart.o_TxSerial = tx_serial_q;
  assign uart.o_TxActive = tx_active_q;
  assign uart.o_TxDone   = tx_done_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Randomized bench for uart_transceiver with a frame-level reference model
// for both directions and a loopback run.
module tb_uart_transceiver;
  localparam int unsigned C = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loop_en = 1'b0;
  logic rx_drv = 1'b1;

  int total = 0;
  int bad   = 0;

  logic [7:0] rxq[$];
  logic       prev_dv = 1'b0;
  int         dv_wide = 0;
  logic [7:0] last_good = 8'h00;

  uart_transceiver_if bif ();

  assign bif.i_RxSerial = loop_en ? bif.o_TxSerial : rx_drv;

  uart_transceiver #(.CLKS_PER_BIT(C)) dut (
    .clk  (clk),
    .rst  (rst),
    .uart (bif)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Collect every received byte; a pulse longer than one cycle is an error.
  always @(negedge clk) begin
    if (bif.o_Rx_DV) begin
      rxq.push_back(bif.o_RxByte);
      if (prev_dv) dv_wide++;
    end
    prev_dv <= bif.o_Rx_DV;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Sends one byte and checks the line against the ideal 10-bit frame.
  task automatic tx_frame(input logic [7:0] b, input bit hold);
    logic [9:0] frame;
    logic [7:0] decoded;
    int line_err, act_cnt, done_cnt, done_pos_err;
    frame = {1'b1, b, 1'b0};
    decoded = 8'h00;
    line_err = 0; act_cnt = 0; done_cnt = 0; done_pos_err = 0;
    @(negedge clk);
    bif.i_TxByte = b;
    bif.i_Tx_DV  = 1'b1;
    for (int j = 0; j < int'(11 * C); j++) begin
      logic exp_line;
      @(negedge clk);
      if (j == 0) begin
        bif.i_TxByte = 8'($urandom);
        if (!hold) bif.i_Tx_DV = 1'b0;
      end
      exp_line = (j < int'(10 * C)) ? frame[j / int'(C)] : 1'b1;
      if (bif.o_TxSerial !== exp_line) line_err++;
      if (bif.o_TxActive) act_cnt++;
      if (bif.o_TxDone) begin
        done_cnt++;
        if (j != int'(10 * C)) done_pos_err++;
        if (hold) bif.i_Tx_DV = 1'b0;
      end
      if ((j % int'(C)) == int'(C / 2) && (j / int'(C)) >= 1 && (j / int'(C)) <= 8)
        decoded[j / int'(C) - 1] = bif.o_TxSerial;
    end
    bif.i_Tx_DV = 1'b0;
    chk("tx_line", 32'(line_err), 32'd0);
    chk("tx_active_cycles", 32'(act_cnt), 32'(10 * C));
    chk("tx_done_cycles", 32'(done_cnt), 32'd1);
    chk("tx_done_pos", 32'(done_pos_err), 32'd0);
    chk("tx_decoded", 32'(decoded), 32'(b));
  endtask

  // Drives a bit-accurate frame on the RX pin, then idles.
  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = frame[k];
      repeat (C) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (3 * C) @(negedge clk);
  endtask

  task automatic rx_expect_one(input logic [7:0] b);
    chk("rx_count", 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) chk("rx_byte", 32'(rxq[0]), 32'(b));
    chk("rx_hold", 32'(bif.o_RxByte), 32'(b));
    rxq.delete();
  endtask

  initial begin
    bif.i_TxByte = 8'h00;
    bif.i_Tx_DV  = 1'b0;
    #2;
    @(negedge clk);
    chk("rst_txserial", 32'(bif.o_TxSerial), 32'd1);
    chk("rst_txactive", 32'(bif.o_TxActive), 32'd0);
    chk("rst_txdone", 32'(bif.o_TxDone), 32'd0);
    chk("rst_rxdv", 32'(bif.o_Rx_DV), 32'd0);
    chk("rst_rxbyte", 32'(bif.o_RxByte), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    tx_frame(8'hA5, 1'b0);
    tx_frame(8'h5A, 1'b1);
    for (int i = 0; i < 3; i++) tx_frame(8'($urandom), 1'b0);
    tx_frame(8'($urandom), 1'b1);

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    bif.i_TxByte = 8'h96;
    bif.i_Tx_DV  = 1'b1;
    @(negedge clk);
    bif.i_Tx_DV  = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_rst_active", 32'(bif.o_TxActive), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_txserial", 32'(bif.o_TxSerial), 32'd1);
    chk("async_rst_txactive", 32'(bif.o_TxActive), 32'd0);
    chk("async_rst_txdone", 32'(bif.o_TxDone), 32'd0);
    chk("async_rst_rxdv", 32'(bif.o_Rx_DV), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tx_frame(8'($urandom), 1'b0);

    // Receive path.
    rxq.delete();
    rx_send(8'h3C, 1'b1);
    rx_expect_one(8'h3C);
    last_good = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] rb;
      rb = 8'($urandom);
      rx_send(rb, 1'b1);
      rx_expect_one(rb);
      last_good = rb;
    end

    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * C) @(negedge clk);
    chk("rx_glitch_count", 32'(rxq.size()), 32'd0);
    chk("rx_glitch_hold", 32'(bif.o_RxByte), 32'(last_good));

    rx_send(8'($urandom), 1'b0);
    chk("rx_frame_err_count", 32'(rxq.size()), 32'd0);
    chk("rx_frame_err_hold", 32'(bif.o_RxByte), 32'(last_good));
    rxq.delete();

    // Loopback with back-to-back frames.
    begin
      logic [7:0] lb[3];
      int seen;
      lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h55;
      loop_en = 1'b1;
      repeat (2) @(negedge clk);
      bif.i_TxByte = lb[0];
      bif.i_Tx_DV  = 1'b1;
      for (int f = 0; f < 3; f++) begin
        seen = 0;
        for (int k = 0; k < int'(12 * C) && seen == 0; k++) begin
          @(negedge clk);
          if (bif.o_TxDone) seen = 1;
        end
        chk("loop_done_seen", 32'(seen), 32'd1);
        if (f < 2) bif.i_TxByte = lb[f + 1];
        else       bif.i_Tx_DV  = 1'b0;
      end
      repeat (3 * C) @(negedge clk);
      chk("loop_count", 32'(rxq.size()), 32'd3);
      for (int f = 0; f < 3; f++)
        chk("loop_byte", (f < rxq.size()) ? 32'(rxq[f]) : 32'hFFFF_FFFF, 32'(lb[f]));
      loop_en = 1'b0;
    end

    chk("rx_dv_width", 32'(dv_wide), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_transceiver.md
# uart_transceiver

8N1 UART serial core: an independent receiver and transmitter that share one clock and one reset. The bit period is a fixed number of clock cycles, with no oversampling clock. The block sits under the memory-mapped I/O of the data memory. That logic writes a byte plus a level-held valid to transmit, and polls done/active/received-byte flags.

## Interface
- CLKS_PER_BIT, default 7292 — clock cycles per serial bit (70 MHz / 9600 bps); legal range ≥ 4.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_RxSerial  in  1  serial receive line; idle high.
- o_RxByte  out  8  last correctly received byte; holds until the next one.
- o_Rx_DV  out  1  one-cycle pulse when o_RxByte is updated.
- i_TxByte  in  8  byte to send; sampled on start.
- i_Tx_DV  in  1  start request; may be held high by the user until o_TxDone.
- o_TxSerial  out  1  serial transmit line; idle high.
- o_TxActive  out  1  high while a frame is on the line.
- o_TxDone  out  1  one-cycle pulse at frame completion.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- **Reset values:**
  - o_TxSerial=1, o_TxActive=0, o_TxDone=0.
  - o_RxByte=0x00, o_Rx_DV=0.
  - Both FSMs in IDLE; all counters 0.
  - Reset asserted mid-frame aborts immediately; TX line returns high without waiting for a clock.
- **RX input:** i_RxSerial passes through a 2-flop synchronizer before any use.
- **RX FSM:** IDLE → START → DATA → STOP → CLEANUP → IDLE.
  - IDLE: wait for the synchronized line = 0.
  - START: count (CLKS_PER_BIT-1)/2 cycles, then re-sample.
    - If 0, clear the counter and go to DATA.
    - If 1, treat as a glitch and return to IDLE.
  - DATA: every CLKS_PER_BIT cycles, sample one bit into the shift register, bit index 0..7; after bit 7 go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the stop bit.
    - If 1, load o_RxByte and pulse o_Rx_DV for one cycle.
    - If 0 (framing error), discard the byte; o_RxByte is unchanged and there is no pulse.
    - In both cases go to CLEANUP.
  - CLEANUP: one cycle, then IDLE.
- **TX FSM:** IDLE → START → DATA → STOP → CLEANUP → IDLE.
  - IDLE: line=1, active=0. i_Tx_DV=1 at a clock edge latches i_TxByte, drives line=0, sets active=1 and enters START.
  - START: CLKS_PER_BIT cycles of line=0.
  - DATA: 8 bits, CLKS_PER_BIT cycles each, LSB first.
  - STOP: CLKS_PER_BIT cycles of line=1.
  - At the end of STOP: active=0, o_TxDone=1, enter CLEANUP.
  - CLEANUP: one cycle, done then returns to 0. i_Tx_DV is ignored here, so a valid cleared on seeing done never retriggers.
  - i_Tx_DV is ignored in every non-IDLE state; i_TxByte changes mid-frame have no effect.
  - A valid still high on returning to IDLE starts a new frame.
- RX and TX are fully independent; simultaneous activity is allowed, including loopback of o_TxSerial to i_RxSerial.

## Timing
- TX start latency: line goes low on the same edge that samples i_Tx_DV=1 in IDLE.
- TX frame: 10·CLKS_PER_BIT cycles with o_TxActive high, followed by one o_TxDone cycle.
- Minimum spacing between back-to-back TX frame starts: 10·CLKS_PER_BIT + 2 cycles.
- RX sampling:
  - Sample points are at bit centres, (CLKS_PER_BIT-1)/2 + k·CLKS_PER_BIT cycles after the synchronized falling edge, k=1..9.
  - Add 2 cycles of synchronizer delay relative to the pin.
- RX o_Rx_DV: asserted in the cycle after the stop-bit sample, for exactly one cycle.
- Counters are wide enough for CLKS_PER_BIT-1 (≥13 bits at the default).

## Test plan
- **Reset:**
  - Stimulus: CLKS_PER_BIT=8; assert rst asynchronously mid-TX-frame.
  - Required response: o_TxSerial=1, o_TxActive=0, o_TxDone=0, o_Rx_DV=0 without a clock edge; next frame transmits normally.
- **TX 0xA5:**
  - Stimulus: pulse i_Tx_DV.
  - Required response:
    - Line shows 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles.
    - o_TxActive high for 80 cycles.
    - o_TxDone high for exactly 1 cycle.
- **TX level-held valid:**
  - Stimulus: hold i_Tx_DV=1 until o_TxDone is seen, then clear it.
  - Required response: exactly one frame sent, no retrigger.
- **RX 0x3C:**
  - Stimulus: drive a bit-accurate 0x3C frame with stop=1.
  - Required response: o_RxByte=0x3C with a 1-cycle o_Rx_DV.
- **RX errors:**
  - 3-cycle low glitch → no o_Rx_DV.
  - Frame with stop bit 0 → no o_Rx_DV, o_RxByte keeps its previous value.
- **Loopback:**
  - Stimulus: o_TxSerial → i_RxSerial; send 0x00, 0xFF, 0x55 back-to-back.
  - Required response: three o_Rx_DV pulses carrying 0x00, 0xFF, 0x55 in order.
